muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide controller.
// Holds the FSM encoding, datapath sizes and the working-register layout.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MULT_RUN = 2'd1;
    localparam logic [1:0] ST_DIV_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // acc is one bit wider than an operand so Booth can subtract -2^31 without overflow
    typedef struct packed {
        logic [WIDTH:0]   acc;
        logic [WIDTH-1:0] low;
        logic             qbit;
    } work_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = {WIDTH{1'b0}} - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 Booth step for multiply,
// restoring shift/subtract step on operand magnitudes for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic             is_div,
    input  work_t            cur,
    input  logic [WIDTH-1:0] op,
    output work_t            nxt
);

    logic [WIDTH:0] op_ext_s;
    logic [WIDTH:0] booth_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Booth add/subtract selection then arithmetic shift; restoring trial subtract otherwise
    always_comb begin
        op_ext_s  = {op[WIDTH-1], op};
        shifted_s = {cur.acc[WIDTH-1:0], cur.low[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, op};
        booth_s   = cur.acc;
        nxt       = cur;
        case ({cur.low[0], cur.qbit})
            2'b01:   booth_s = cur.acc + op_ext_s;
            2'b10:   booth_s = cur.acc - op_ext_s;
            default: booth_s = cur.acc;
        endcase
        if (is_div) begin
            nxt.qbit = 1'b0;
            if (!trial_s[WIDTH]) begin
                nxt.acc = trial_s;
                nxt.low = {cur.low[WIDTH-2:0], 1'b1};
            end else begin
                nxt.acc = shifted_s;
                nxt.low = {cur.low[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt.acc  = {booth_s[WIDTH], booth_s[WIDTH:1]};
            nxt.low  = {booth_s[0], cur.low[WIDTH-1:1]};
            nxt.qbit = cur.low[0];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative signed multiply/divide controller: 32 datapath steps per
// operation, HI/LO result registers and one-cycle completion pulses.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              MultCtrl,
    input  logic              DivCtrl,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    output logic [WIDTH-1:0]  hi_out,
    output logic [WIDTH-1:0]  lo_out,
    output logic              busy,
    output logic              multStop,
    output logic              DivStop,
    output logic              DivZero
);

    logic [1:0]       state_r;
    logic [4:0]       cnt_r;
    logic             last_r;
    work_t            work_r;
    work_t            work_nx_s;
    logic [WIDTH-1:0] op_r;
    logic             neg_quot_r;
    logic             neg_rem_r;
    logic             dzero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             mult_stop_r;
    logic             div_stop_r;
    logic             div_zero_r;
    logic             is_div_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;

    assign is_div_s = (state_r == ST_DIV_RUN);
    assign hi_out   = hi_r;
    assign lo_out   = lo_r;
    assign busy     = busy_r;
    assign multStop = mult_stop_r;
    assign DivStop  = div_stop_r;
    assign DivZero  = div_zero_r;

    muldiv_step u_step (
        .is_div (is_div_s),
        .cur    (work_r),
        .op     (op_r),
        .nxt    (work_nx_s)
    );

    // Restore operand signs onto the unsigned quotient and remainder
    always_comb begin
        if (neg_quot_r) begin
            quot_s = {WIDTH{1'b0}} - work_r.low;
        end else begin
            quot_s = work_r.low;
        end
        if (neg_rem_r) begin
            rem_s = {WIDTH{1'b0}} - work_r.acc[WIDTH-1:0];
        end else begin
            rem_s = work_r.acc[WIDTH-1:0];
        end
    end

    // Controller FSM, iteration counter, working and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            last_r      <= 1'b0;
            work_r      <= '{acc: {(WIDTH+1){1'b0}}, low: {WIDTH{1'b0}}, qbit: 1'b0};
            op_r        <= {WIDTH{1'b0}};
            neg_quot_r  <= 1'b0;
            neg_rem_r   <= 1'b0;
            dzero_r     <= 1'b0;
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            mult_stop_r <= 1'b0;
            div_stop_r  <= 1'b0;
            div_zero_r  <= 1'b0;
        end else begin
            mult_stop_r <= 1'b0;
            div_stop_r  <= 1'b0;
            div_zero_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (MultCtrl || DivCtrl) begin
                        cnt_r  <= 5'd0;
                        last_r <= 1'b0;
                        busy_r <= 1'b1;
                        // MultCtrl wins when both requests arrive together
                        if (MultCtrl) begin
                            state_r <= ST_MULT_RUN;
                            work_r  <= '{acc: {(WIDTH+1){1'b0}}, low: b_in, qbit: 1'b0};
                            op_r    <= a_in;
                            dzero_r <= 1'b0;
                        end else begin
                            state_r    <= ST_DIV_RUN;
                            work_r     <= '{acc: {(WIDTH+1){1'b0}}, low: magnitude(a_in), qbit: 1'b0};
                            op_r       <= magnitude(b_in);
                            neg_quot_r <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            neg_rem_r  <= a_in[WIDTH-1];
                            dzero_r    <= (b_in == {WIDTH{1'b0}});
                        end
                    end
                end
                ST_MULT_RUN, ST_DIV_RUN: begin
                    if (is_div_s && dzero_r) begin
                        state_r    <= ST_DONE;
                        div_stop_r <= 1'b1;
                        div_zero_r <= 1'b1;
                    end else if (last_r) begin
                        state_r <= ST_DONE;
                        if (is_div_s) begin
                            hi_r       <= rem_s;
                            lo_r       <= quot_s;
                            div_stop_r <= 1'b1;
                        end else begin
                            hi_r        <= work_r.acc[WIDTH-1:0];
                            lo_r        <= work_r.low;
                            mult_stop_r <= 1'b1;
                        end
                    end else begin
                        work_r <= work_nx_s;
                        cnt_r  <= cnt_r + 5'd1;
                        last_r <= (cnt_r == 5'(ITER - 1));
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
